ms_tmp_comp_ser: RTL and testbench

Parametrised multi-lane serial test harness that folds a wide core boundary down to a few pins, so a full processor can be synthesised and timed without all its ports being routed.
- Captures a CLenI-bit parallel vector and shifts it out over CLanes serial lanes.
- Shifts CLenO bits in over the same lanes and updates a CLenO-bit parallel output once per frame.
- Sits between a top-level test wrapper's pins and the MsProcTop boundary.
- Successor to the single-lane MsTmpCompB: adds lane count, framed capture/update and a sync marker.

---
 rtl/ms_tmp_comp_pkg.sv | 24 ++
 rtl/ms_tmp_comp_lane.sv | 79 +++++++
 rtl/ms_tmp_comp_ser.sv | 106 ++++++++++
 tb/tb_ms_tmp_comp_ser.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ms_tmp_comp_pkg.sv
// ms_tmp_comp_pkg: shared state encoding and frame-size helpers for ms_tmp_comp_ser
package ms_tmp_comp_pkg;

   typedef logic [1:0] TState;

   localparam TState CAPTURE = 2'd0;
   localparam TState SHIFT   = 2'd1;
   localparam TState PARITY  = 2'd2;
   localparam TState UPDATE  = 2'd3;

   function automatic int ceilDiv(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // Shift cycles per frame: enough to carry the wider of the two vectors.
   function automatic int frameLen(input int lenI, input int lenO, input int lanes);
      int fi;
      int fo;
      fi = ceilDiv(lenI, lanes);
      fo = ceilDiv(lenO, lanes);
      return (fi > fo) ? fi : fo;
   endfunction

endpackage

// File: rtl/ms_tmp_comp_lane.sv
// ms_tmp_comp_lane: one serial lane (out/in shift slices, parity when MS_TMP_COMP_SER_PARITY_EN)
module ms_tmp_comp_lane
   import ms_tmp_comp_pkg::*;
#(
   parameter int CF = 1
) (
   input  logic          AClkH,
   input  logic          AResetH,
   input  logic          AClkHEn,
   input  logic          ALoad,
   input  logic          AShift,
`ifdef MS_TMP_COMP_SER_PARITY_EN
   input  logic          ALast,
   output logic          AParBad,
`endif
   input  logic [CF-1:0] ADataI,
   input  logic          ASerI,
   output logic          ASerO,
   output logic [CF-1:0] AShadowO
);

   logic [CF-1:0] shOut;
   logic [CF:0]   shIn;

   assign shIn = {ASerI, AShadowO};

`ifdef MS_TMP_COMP_SER_PARITY_EN
   logic parOut;
   logic parIn;

   assign AParBad = ASerI ^ parIn;

   // Lane shifters plus sent/received parity; parity bit goes out right after the last data bit.
   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         shOut    <= '0;
         AShadowO <= '0;
         ASerO    <= 1'b0;
         parOut   <= 1'b0;
         parIn    <= 1'b0;
      end else if (AClkHEn) begin
         if (ALoad) begin
            shOut  <= ADataI >> 1;
            ASerO  <= ADataI[0];
            parOut <= ^ADataI;
            parIn  <= 1'b0;
         end else if (AShift) begin
            shOut    <= shOut >> 1;
            AShadowO <= shIn[CF:1];
            ASerO    <= ALast ? parOut : shOut[0];
            parIn    <= parIn ^ ASerI;
         end else begin
            ASerO <= 1'b0;
         end
      end
   end
`else
   // Lane shifters; after the last data bit the drained out-slice leaves ASerO at 0.
   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         shOut    <= '0;
         AShadowO <= '0;
         ASerO    <= 1'b0;
      end else if (AClkHEn) begin
         if (ALoad) begin
            shOut <= ADataI >> 1;
            ASerO <= ADataI[0];
         end else if (AShift) begin
            shOut    <= shOut >> 1;
            AShadowO <= shIn[CF:1];
            ASerO    <= shOut[0];
         end else begin
            ASerO <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: rtl/ms_tmp_comp_ser.sv
// ms_tmp_comp_ser: multi-lane framed serial harness folding a wide core boundary onto a few pins (optional lane parity: MS_TMP_COMP_SER_PARITY_EN)
module ms_tmp_comp_ser
   import ms_tmp_comp_pkg::*;
#(
   parameter int CLenI  = 64,
   parameter int CLenO  = 64,
   parameter int CLanes = 1
) (
   input  logic              AClkH,
   input  logic              AResetH,
   input  logic              AClkHEn,
   input  logic [CLenI-1:0]  ADataI,
   output logic [CLenO-1:0]  ADataO,
   input  logic [CLanes-1:0] ASerI,
   output logic [CLanes-1:0] ASerO,
   output logic              ASyncO,
   output logic              AParErr
);

   localparam int CF    = frameLen(CLenI, CLenO, CLanes);
   localparam int CW    = CF * CLanes;
   localparam int CCntW = $clog2(CF + 1);

   TState            state;
   TState            stateNxt;
   logic [CCntW-1:0] cnt;
   logic             last;
   logic             updOk;
   logic [CW-1:0]    padI;
   logic [CW-1:0]    shadowO;

   assign padI = CW'(ADataI);
   assign last = (cnt == CCntW'(CF - 1));

`ifdef MS_TMP_COMP_SER_PARITY_EN
   logic [CLanes-1:0] parBad;

   assign updOk = !AParErr;
`else
   assign updOk   = 1'b1;
   assign AParErr = 1'b0;
`endif

   // Next-state selection; the parity slot is only present when the feature is built in.
   always_comb begin
      stateNxt = CAPTURE;
`ifdef MS_TMP_COMP_SER_PARITY_EN
      stateNxt = (state == CAPTURE) ? SHIFT :
                 (state == SHIFT)   ? (last ? PARITY : SHIFT) :
                 (state == PARITY)  ? UPDATE : CAPTURE;
`else
      stateNxt = (state == CAPTURE) ? SHIFT :
                 (state == SHIFT)   ? (last ? UPDATE : SHIFT) : CAPTURE;
`endif
   end

   // Frame sequencing, sync marker and the once-per-frame parallel output update.
   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         state  <= CAPTURE;
         cnt    <= '0;
         ADataO <= '0;
         ASyncO <= 1'b0;
      end else if (AClkHEn) begin
         state  <= stateNxt;
         cnt    <= (state == SHIFT) ? cnt + 1'b1 : '0;
         ASyncO <= (state == CAPTURE);
         ADataO <= (state == UPDATE && updOk) ? shadowO[CLenO-1:0] : ADataO;
      end
   end

`ifdef MS_TMP_COMP_SER_PARITY_EN
   // Parity verdict is latched in PARITY so it is visible, and gates the update, during UPDATE.
   always_ff @(posedge AClkH) begin
      if (AResetH)
         AParErr <= 1'b0;
      else if (AClkHEn)
         AParErr <= (state == PARITY) && (|parBad);
   end
`endif

   for (genvar l = 0; l < CLanes; l++) begin : gLane
      logic [CF-1:0] laneI;
      logic [CF-1:0] laneO;
      for (genvar k = 0; k < CF; k++) begin : gBit
         assign laneI[k]               = padI[k*CLanes + l];
         assign shadowO[k*CLanes + l]  = laneO[k];
      end
      ms_tmp_comp_lane #(.CF(CF)) uLane (
         .AClkH    (AClkH),
         .AResetH  (AResetH),
         .AClkHEn  (AClkHEn),
         .ALoad    (state == CAPTURE),
         .AShift   (state == SHIFT),
`ifdef MS_TMP_COMP_SER_PARITY_EN
         .ALast    (last),
         .AParBad  (parBad[l]),
`endif
         .ADataI   (laneI),
         .ASerI    (ASerI[l]),
         .ASerO    (ASerO[l]),
         .AShadowO (laneO)
      );
   end

endmodule

// File: tb/tb_ms_tmp_comp_ser.sv
// tb_ms_tmp_comp_ser: directed table-driven bench for ms_tmp_comp_ser (CLenI=10, CLenO=6, CLanes=2)
module tb_ms_tmp_comp_ser;

   localparam int CF = 5;

   typedef struct {
      logic [9:0] dataI;
      logic [9:0] serIn;
      logic [9:0] expSer;
      logic [5:0] expDataO;
   } TVec;

   logic       AClkH = 1'b0;
   logic       AResetH;
   logic       AClkHEn;
   logic [9:0] ADataI;
   logic [5:0] ADataO;
   logic [1:0] ASerI;
   logic [1:0] ASerO;
   logic       ASyncO;
   logic       AParErr;

   int         nTests = 0;
   int         nFail  = 0;
   logic [5:0] expPrev;
   TVec        vecs [4];

   ms_tmp_comp_ser #(.CLenI(10), .CLenO(6), .CLanes(2)) dut (
      .AClkH   (AClkH),
      .AResetH (AResetH),
      .AClkHEn (AClkHEn),
      .ADataI  (ADataI),
      .ADataO  (ADataO),
      .ASerI   (ASerI),
      .ASerO   (ASerO),
      .ASyncO  (ASyncO),
      .AParErr (AParErr)
   );

   always #5 AClkH = ~AClkH;

   task automatic step();
      @(posedge AClkH);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One full frame starting in CAPTURE; corrupt flips lane 0's parity bit.
   task automatic runFrame(input TVec v, input logic corrupt);
      logic [1:0] parS;
      logic [1:0] parR;
      parS    = '0;
      parR    = '0;
      ADataI  = v.dataI;
      ASerI   = '0;
      step();
      for (int k = 0; k < CF; k++) begin
         check("serO", 32'(ASerO), 32'(v.expSer[2*k +: 2]));
         check("sync", 32'(ASyncO), 32'(k == 0));
         check("holdShift", 32'(ADataO), 32'(expPrev));
         ASerI = v.serIn[2*k +: 2];
         parS  = parS ^ v.expSer[2*k +: 2];
         parR  = parR ^ ASerI;
         step();
      end
`ifdef MS_TMP_COMP_SER_PARITY_EN
      check("parOut", 32'(ASerO), 32'(parS));
      ASerI = parR ^ {1'b0, corrupt};
      step();
      check("parErrUpd", 32'(AParErr), 32'(corrupt));
`endif
      ASerI = '0;
      check("serOUpd", 32'(ASerO), 32'h0);
      check("syncUpd", 32'(ASyncO), 32'h0);
      check("holdUpd", 32'(ADataO), 32'(expPrev));
      step();
      if (!corrupt)
         expPrev = v.expDataO;
      check("dataO", 32'(ADataO), 32'(expPrev));
      check("parErrCap", 32'(AParErr), 32'h0);
      check("serOCap", 32'(ASerO), 32'h0);
   endtask

   initial begin
      logic [1:0] parR;
      // ASerO pairs {lane1,lane0} per cycle packed low-cycle first; padding ASerI bits sit in [9:6].
      vecs[0] = '{dataI: 10'h2B5, serIn: 10'h3ED, expSer: 10'b10_10_11_01_01, expDataO: 6'h2D};
      vecs[1] = '{dataI: 10'h3FF, serIn: 10'h000, expSer: 10'b11_11_11_11_11, expDataO: 6'h00};
      vecs[2] = '{dataI: 10'h001, serIn: 10'h015, expSer: 10'b00_00_00_00_01, expDataO: 6'h15};
      vecs[3] = '{dataI: 10'h200, serIn: 10'h3EA, expSer: 10'b10_00_00_00_00, expDataO: 6'h2A};

      AResetH = 1'b1;
      AClkHEn = 1'b1;
      ADataI  = '0;
      ASerI   = '0;
      expPrev = '0;
      repeat (3) step();
      check("rstDataO", 32'(ADataO), 32'h0);
      check("rstSerO", 32'(ASerO), 32'h0);
      check("rstSync", 32'(ASyncO), 32'h0);
      check("rstParErr", 32'(AParErr), 32'h0);
      AResetH = 1'b0;

      foreach (vecs[i])
         runFrame(vecs[i], 1'b0);

      // Clock-enable gaps inside the frame must neither advance nor sample.
      ADataI = vecs[0].dataI;
      ASerI  = '0;
      parR   = '0;
      step();
      AClkHEn = 1'b0;
      step();
      check("enSyncHold", 32'(ASyncO), 32'h1);
      check("enSerHold", 32'(ASerO), 32'(vecs[0].expSer[1:0]));
      for (int k = 0; k < CF; k++) begin
         check("enSer", 32'(ASerO), 32'(vecs[0].expSer[2*k +: 2]));
         ASerI   = vecs[0].serIn[2*k +: 2];
         parR    = parR ^ ASerI;
         AClkHEn = 1'b1;
         step();
         ASerI   = ~vecs[0].serIn[2*k +: 2];
         AClkHEn = 1'b0;
         step();
      end
      AClkHEn = 1'b1;
`ifdef MS_TMP_COMP_SER_PARITY_EN
      ASerI = parR;
      step();
`endif
      ASerI = '0;
      check("enHold", 32'(ADataO), 32'(expPrev));
      step();
      expPrev = vecs[0].expDataO;
      check("enDataO", 32'(ADataO), 32'(expPrev));

      // Reset two cycles into SHIFT aborts the frame; the next frame restarts at CAPTURE.
      ADataI = 10'h155;
      step();
      ASerI = 2'b11;
      step();
      step();
      AResetH = 1'b1;
      step();
      expPrev = '0;
      check("abortDataO", 32'(ADataO), 32'h0);
      check("abortSerO", 32'(ASerO), 32'h0);
      check("abortSync", 32'(ASyncO), 32'h0);
      AResetH = 1'b0;
      check("abortSyncPre", 32'(ASyncO), 32'h0);
      runFrame(vecs[3], 1'b0);

`ifdef MS_TMP_COMP_SER_PARITY_EN
      runFrame(vecs[2], 1'b1);
      runFrame(vecs[0], 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
